// File: rtl/sramlike_axi_bridge_if.sv
// Bundled SRAM-like request ports (inst/data) and AXI3 master channels for the bridge.
// The master modport is the bridge side; the slave modport is the SRAM requesters plus AXI slave.
interface sramlike_axi_bridge_if;
  logic        inst_req, inst_wr, inst_uncached;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;

  logic        data_req, data_wr, data_uncached;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;

  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;

  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  modport master (
    input  inst_req, inst_wr, inst_uncached, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_uncached, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_uncached, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_uncached, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// Two-port SRAM-like to AXI3 bridge: single outstanding single-beat transaction,
// data port wins arbitration over inst port.
module sramlike_axi_bridge (
  input logic                   clk,
  input logic                   rst,
  sramlike_axi_bridge_if.master bus
);
  typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB} state_e;

  state_e      r_state;
  logic        r_id, r_wr, r_uncached;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic        r_arvalid, r_awvalid, r_wvalid, r_rready, r_bready;
  logic        r_aw_done, r_w_done;

  logic        w_idle, w_req, w_sel_data, w_wr, w_uncached;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata;
  logic        w_aw_fin, w_w_fin, w_resp;
  logic [3:0]  w_wstrb;
  logic        w_unused;

  assign w_idle     = (r_state == StIdle);
  assign w_sel_data = bus.data_req;
  assign w_req      = bus.data_req | bus.inst_req;
  assign w_wr       = w_sel_data ? bus.data_wr       : bus.inst_wr;
  assign w_uncached = w_sel_data ? bus.data_uncached : bus.inst_uncached;
  assign w_size     = w_sel_data ? bus.data_size     : bus.inst_size;
  assign w_addr     = w_sel_data ? bus.data_addr     : bus.inst_addr;
  assign w_wdata    = w_sel_data ? bus.data_wdata    : bus.inst_wdata;

  // A handshake in the current cycle counts as done, so simultaneous AW/W goes straight to B.
  assign w_aw_fin = r_aw_done | (r_awvalid & bus.awready);
  assign w_w_fin  = r_w_done  | (r_wvalid  & bus.wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_id       <= 1'b0;
      r_wr       <= 1'b0;
      r_uncached <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_rready   <= 1'b0;
      r_bready   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req) begin
            r_id       <= w_sel_data;
            r_wr       <= w_wr;
            r_uncached <= w_uncached;
            r_size     <= w_size;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            if (w_wr) begin
              r_state   <= StAwW;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= StAr;
              r_arvalid <= 1'b1;
            end
          end
        end
        StAr: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (bus.rvalid) begin
            r_rready <= 1'b0;
            r_state  <= StIdle;
          end
        end
        StAwW: begin
          if (r_awvalid && bus.awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && bus.wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= StB;
          end
        end
        StB: begin
          if (bus.bvalid) begin
            r_bready <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_wstrb = 4'b1111;
    unique case (r_size)
      2'b00:   w_wstrb = 4'b0001 << r_addr[1:0];
      2'b01:   w_wstrb = 4'b0011 << r_addr[1:0];
      default: w_wstrb = 4'b1111;
    endcase
  end

  assign w_resp = ~rst & (((r_state == StR) & bus.rvalid) | ((r_state == StB) & bus.bvalid));

  assign bus.data_addr_ok = w_idle & bus.data_req;
  assign bus.inst_addr_ok = w_idle & bus.inst_req & ~bus.data_req;
  assign bus.data_data_ok = w_resp & r_id;
  assign bus.inst_data_ok = w_resp & ~r_id;
  assign bus.data_rdata   = bus.rdata;
  assign bus.inst_rdata   = bus.rdata;

  assign bus.arid    = {3'b000, r_id};
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 4'h0;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = r_uncached ? 4'b0000 : 4'b1111;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awid    = {3'b000, r_id};
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 4'h0;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = r_uncached ? 4'b0000 : 4'b1111;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = r_awvalid;

  assign bus.wid    = {3'b000, r_id};
  assign bus.wdata  = r_wdata;
  assign bus.wstrb  = w_wstrb;
  assign bus.wlast  = 1'b1;
  assign bus.wvalid = r_wvalid;
  assign bus.bready = r_bready;

  // Response ids/status are not used; r_wr is kept for visibility of the latched request.
  assign w_unused = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, r_wr};
endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed self-checking bench for sramlike_axi_bridge: reads, writes, arbitration,
// AR back-pressure and mid-transaction reset.
module tb_sramlike_axi_bridge;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  sramlike_axi_bridge_if bus ();

  sramlike_axi_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic is_data, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic uncached);
    if (is_data) begin
      bus.data_req = 1'b1; bus.data_wr = wr; bus.data_size = size;
      bus.data_addr = addr; bus.data_wdata = wdata; bus.data_uncached = uncached;
    end else begin
      bus.inst_req = 1'b1; bus.inst_wr = wr; bus.inst_size = size;
      bus.inst_addr = addr; bus.inst_wdata = wdata; bus.inst_uncached = uncached;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_uncached = 0; bus.inst_size = 0;
    bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_uncached = 0; bus.data_size = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    bus.rvalid = 0; bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0;
    bus.bvalid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valids got %b want 00000",
               {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready});
    end
    total++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL reset_data_ok got %b want 00", {bus.inst_data_ok, bus.data_data_ok});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hDEADBEEF;
    set_req(1'b1, 1'b0, 2'd2, 32'h1FC0_0000, 32'h0, 1'b1);
    total++;
    if ({bus.data_addr_ok, bus.inst_addr_ok} !== 2'b10) begin
      bad++; $display("FAIL read_addr_ok got %b want 10", {bus.data_addr_ok, bus.inst_addr_ok});
    end
    tick();
    bus.data_req = 0;
    #1;
    total++;
    if ({bus.arvalid, bus.araddr, bus.arsize, bus.arcache, bus.arid}
        !== {1'b1, 32'h1FC0_0000, 3'd2, 4'h0, 4'h1}) begin
      bad++;
      $display("FAIL read_ar got v=%b a=%h s=%0d c=%h id=%0d want 1 1fc00000 2 0 1",
               bus.arvalid, bus.araddr, bus.arsize, bus.arcache, bus.arid);
    end
    total++;
    if ({bus.arlen, bus.arburst, bus.arlock, bus.arprot, bus.data_data_ok}
        !== {4'h0, 2'b01, 2'b00, 3'b000, 1'b0}) begin
      bad++;
      $display("FAIL read_ar_fixed got len=%h burst=%b lock=%b prot=%b ok=%b want 0 01 00 000 0",
               bus.arlen, bus.arburst, bus.arlock, bus.arprot, bus.data_data_ok);
    end
    tick();
    total++;
    if ({bus.rready, bus.data_data_ok, bus.inst_data_ok, bus.data_rdata}
        !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL read_data got rr=%b dok=%b iok=%b rd=%h want 1 1 0 deadbeef",
               bus.rready, bus.data_data_ok, bus.inst_data_ok, bus.data_rdata);
    end
    tick();
    total++;
    if ({bus.rready, bus.data_data_ok, bus.arvalid} !== 3'b000) begin
      bad++;
      $display("FAIL read_done got rr=%b ok=%b arv=%b want 000",
               bus.rready, bus.data_data_ok, bus.arvalid);
    end
    bus.arready = 0; bus.rvalid = 0;
    #1;
  endtask

  task automatic test_priority();
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h1111_2222;
    set_req(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 1'b0);
    total++;
    if ({bus.data_addr_ok, bus.inst_addr_ok} !== 2'b10) begin
      bad++; $display("FAIL prio_addr_ok got %b want 10", {bus.data_addr_ok, bus.inst_addr_ok});
    end
    tick();
    bus.data_req = 0;
    #1;
    total++;
    if ({bus.inst_addr_ok, bus.araddr} !== {1'b0, 32'h0000_0200}) begin
      bad++;
      $display("FAIL prio_busy got iaok=%b a=%h want 0 00000200", bus.inst_addr_ok, bus.araddr);
    end
    tick();
    total++;
    if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b10) begin
      bad++; $display("FAIL prio_data_ok got %b want 10", {bus.data_data_ok, bus.inst_data_ok});
    end
    tick();
    total++;
    if (bus.inst_addr_ok !== 1'b1) begin
      bad++; $display("FAIL prio_inst_accept got %b want 1", bus.inst_addr_ok);
    end
    tick();
    bus.inst_req = 0;
    #1;
    total++;
    if ({bus.arid, bus.araddr} !== {4'h0, 32'h0000_0100}) begin
      bad++; $display("FAIL prio_inst_ar got id=%0d a=%h want 0 00000100", bus.arid, bus.araddr);
    end
    tick();
    total++;
    if ({bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata} !== {2'b10, 32'h1111_2222}) begin
      bad++;
      $display("FAIL prio_inst_data got iok=%b dok=%b rd=%h want 1 0 11112222",
               bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata);
    end
    tick();
    bus.arready = 0; bus.rvalid = 0;
    #1;
  endtask

  task automatic test_byte_write();
    bus.wready = 1;
    set_req(1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'hAB00_0000, 1'b0);
    tick();
    bus.data_req = 0;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.wstrb, bus.awsize, bus.awcache, bus.awid, bus.wid}
        !== {2'b11, 4'b1000, 3'd0, 4'hF, 4'h1, 4'h1}) begin
      bad++;
      $display("FAIL bw_aw got awv=%b wv=%b st=%b sz=%0d c=%h id=%0d wid=%0d want 1 1 1000 0 f 1 1",
               bus.awvalid, bus.wvalid, bus.wstrb, bus.awsize, bus.awcache, bus.awid, bus.wid);
    end
    total++;
    if ({bus.awaddr, bus.wdata, bus.wlast, bus.awburst, bus.awlen}
        !== {32'h0000_1003, 32'hAB00_0000, 1'b1, 2'b01, 4'h0}) begin
      bad++;
      $display("FAIL bw_fixed got a=%h d=%h last=%b burst=%b len=%h want 00001003 ab000000 1 01 0",
               bus.awaddr, bus.wdata, bus.wlast, bus.awburst, bus.awlen);
    end
    tick();
    bus.wready = 0;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b100) begin
      bad++;
      $display("FAIL bw_w_first got awv=%b wv=%b br=%b want 100",
               bus.awvalid, bus.wvalid, bus.bready);
    end
    tick();
    tick();
    bus.awready = 1;
    #1;
    total++;
    if ({bus.awvalid, bus.bready} !== 2'b10) begin
      bad++; $display("FAIL bw_aw_wait got awv=%b br=%b want 10", bus.awvalid, bus.bready);
    end
    tick();
    bus.awready = 0;
    #1;
    total++;
    if ({bus.awvalid, bus.bready, bus.data_data_ok} !== 3'b010) begin
      bad++;
      $display("FAIL bw_b got awv=%b br=%b ok=%b want 010",
               bus.awvalid, bus.bready, bus.data_data_ok);
    end
    bus.bvalid = 1;
    #1;
    total++;
    if ({bus.data_data_ok, bus.inst_data_ok} !== 2'b10) begin
      bad++; $display("FAIL bw_data_ok got %b want 10", {bus.data_data_ok, bus.inst_data_ok});
    end
    tick();
    bus.bvalid = 0;
    #1;
    total++;
    if ({bus.bready, bus.data_data_ok} !== 2'b00) begin
      bad++; $display("FAIL bw_done got br=%b ok=%b want 00", bus.bready, bus.data_data_ok);
    end
  endtask

  task automatic test_half_write();
    bus.awready = 1; bus.wready = 1;
    set_req(1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h5A5A_0000, 1'b1);
    tick();
    bus.inst_req = 0;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.wstrb, bus.awid, bus.awsize, bus.awcache}
        !== {2'b11, 4'b1100, 4'h0, 3'd1, 4'h0}) begin
      bad++;
      $display("FAIL hw_aw got awv=%b wv=%b st=%b id=%0d sz=%0d c=%h want 1 1 1100 0 1 0",
               bus.awvalid, bus.wvalid, bus.wstrb, bus.awid, bus.awsize, bus.awcache);
    end
    tick();
    bus.awready = 0; bus.wready = 0; bus.bvalid = 1;
    #1;
    total++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.inst_data_ok, bus.data_data_ok}
        !== 5'b00110) begin
      bad++;
      $display("FAIL hw_b got awv=%b wv=%b br=%b iok=%b dok=%b want 00110",
               bus.awvalid, bus.wvalid, bus.bready, bus.inst_data_ok, bus.data_data_ok);
    end
    tick();
    bus.bvalid = 0;
    #1;
  endtask

  task automatic test_ar_stall();
    set_req(1'b1, 1'b0, 2'd2, 32'h8000_0040, 32'h0, 1'b0);
    tick();
    bus.inst_req = 1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.arvalid, bus.araddr, bus.arcache, bus.data_addr_ok, bus.inst_addr_ok}
          !== {1'b1, 32'h8000_0040, 4'hF, 2'b00}) begin
        bad++;
        $display("FAIL stall_%0d got v=%b a=%h c=%h daok=%b iaok=%b want 1 80000040 f 0 0",
                 i, bus.arvalid, bus.araddr, bus.arcache, bus.data_addr_ok, bus.inst_addr_ok);
      end
      tick();
    end
    bus.arready = 1;
    #1;
    tick();
    bus.arready = 0; bus.inst_req = 0; bus.data_req = 0;
    bus.rvalid = 1; bus.rdata = 32'h1234_5678;
    #1;
    total++;
    if ({bus.arvalid, bus.data_data_ok, bus.data_rdata} !== {2'b01, 32'h1234_5678}) begin
      bad++;
      $display("FAIL stall_data got arv=%b ok=%b rd=%h want 0 1 12345678",
               bus.arvalid, bus.data_data_ok, bus.data_rdata);
    end
    tick();
    bus.rvalid = 0;
    #1;
  endtask

  task automatic test_reset_mid();
    bus.arready = 1;
    set_req(1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 1'b1);
    tick();
    bus.data_req = 0;
    #1;
    tick();
    bus.arready = 0;
    #1;
    total++;
    if (bus.rready !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_r got rready=%b want 1", bus.rready);
    end
    rst = 1;
    tick();
    rst = 0;
    bus.rvalid = 1; bus.rdata = 32'hBAD0_BAD0;
    #1;
    total++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
         bus.data_data_ok, bus.inst_data_ok} !== 7'b0) begin
      bad++;
      $display("FAIL rstmid_idle got %b want 0000000",
               {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                bus.data_data_ok, bus.inst_data_ok});
    end
    bus.data_req = 1;
    #1;
    total++;
    if (bus.data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL rstmid_accepts got %b want 1", bus.data_addr_ok);
    end
    bus.data_req = 0;
    tick();
    total++;
    if ({bus.arvalid, bus.data_data_ok} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_stale got arv=%b ok=%b want 00", bus.arvalid, bus.data_data_ok);
    end
    bus.rvalid = 0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1;
    test_reset();
    test_read();
    test_priority();
    test_byte_write();
    test_half_write();
    test_ar_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
